// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t : control FSM encoding (IDLE accepts operands, BUSY shifts one
//             bit per clock, DONE presents the result until it is taken).
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width: wide enough to count 0..width-1, never below one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor cell, purely combinational.
//   a_i      : minuend bit
//   b_i      : subtrahend bit
//   borrow_i : borrow from the previous (less significant) bit
//   diff_o   : difference bit
//   borrow_o : borrow into the next (more significant) bit
module full_sub (
    input  logic a_i,
    input  logic b_i,
    input  logic borrow_i,
    output logic diff_o,
    output logic borrow_o
);

    assign diff_o   = a_i ^ b_i ^ borrow_i;
    assign borrow_o = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_i);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes (a_i - b_i) mod 2^width_p one bit per clock,
// LSB first, with a valid/ready handshake on both sides.
//   clk_i    : clock, all state on the rising edge
//   reset_i  : synchronous active-high reset, clears every register
//   valid_i  : operands presented (taken only while ready_o is high)
//   ready_o  : block is idle and can accept operands
//   a_i, b_i : minuend and subtrahend
//   valid_o  : result available (held until ready_i)
//   ready_i  : consumer takes the result
//   diff_o   : difference, holds the last completed result
//   borrow_o : final borrow, 1 when a_i < b_i unsigned
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [width_p-1:0] diff_o,
    output logic               borrow_o
);

    localparam int cnt_w_lp = cnt_width(width_p);
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(width_p - 1);

    state_t               state_reg;
    state_t               state_next;
    logic [width_p-1:0]   a_reg;
    logic [width_p-1:0]   b_reg;
    logic [width_p-1:0]   work_reg;
    logic [width_p-1:0]   work_next;
    logic                 bw_reg;
    logic [cnt_w_lp-1:0]  cnt_reg;
    logic [width_p-1:0]   diff_reg;
    logic                 borrow_reg;
    logic                 bit_diff;
    logic                 bit_borrow;
    logic                 last_bit;

    full_sub u_full_sub (
        .a_i      (a_reg[0]),
        .b_i      (b_reg[0]),
        .borrow_i (bw_reg),
        .diff_o   (bit_diff),
        .borrow_o (bit_borrow)
    );

    // New difference bit enters at the MSB so that after width_p shifts the
    // first (LSB) result bit has arrived at bit 0.
    generate
        if (width_p == 1) begin : g_work_one
            assign work_next = bit_diff;
        end else begin : g_work_wide
            assign work_next = {bit_diff, work_reg[width_p-1:1]};
        end
    endgenerate

    assign last_bit = (cnt_reg == last_cnt_lp);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (valid_i)  state_next = BUSY;
            BUSY:    if (last_bit) state_next = DONE;
            DONE:    if (ready_i)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_reg      <= '0;
            b_reg      <= '0;
            work_reg   <= '0;
            bw_reg     <= 1'b0;
            cnt_reg    <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid_i) begin
                        a_reg    <= a_i;
                        b_reg    <= b_i;
                        work_reg <= '0;
                        bw_reg   <= 1'b0;
                        cnt_reg  <= '0;
                    end
                end
                BUSY: begin
                    a_reg    <= a_reg >> 1;
                    b_reg    <= b_reg >> 1;
                    work_reg <= work_next;
                    bw_reg   <= bit_borrow;
                    if (last_bit) begin
                        // Counter parks at width_p-1 instead of wrapping.
                        diff_reg   <= work_next;
                        borrow_reg <= bit_borrow;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o  = (state_reg == IDLE);
    assign valid_o  = (state_reg == DONE);
    assign diff_o   = diff_reg;
    assign borrow_o = borrow_reg;

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // width_p = 8 instance
    logic       v8, rdy8, vo8, ri8, bo8;
    logic [7:0] a8, b8, d8;
    // width_p = 2 instance
    logic       v2, rdy2, vo2, ri2, bo2;
    logic [1:0] a2, b2, d2;

    logic error_o;
    logic pass_o;

    serial_sub #(.width_p(8)) u_dut8 (
        .clk_i(clk), .reset_i(rst), .valid_i(v8), .ready_o(rdy8),
        .a_i(a8), .b_i(b8), .valid_o(vo8), .ready_i(ri8),
        .diff_o(d8), .borrow_o(bo8)
    );

    serial_sub #(.width_p(2)) u_dut2 (
        .clk_i(clk), .reset_i(rst), .valid_i(v2), .ready_o(rdy2),
        .a_i(a2), .b_i(b2), .valid_o(vo2), .ready_i(ri2),
        .diff_o(d2), .borrow_o(bo2)
    );

    typedef struct {
        logic [7:0] diff;
        logic       borrow;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic get_valid(input bit sel);
        return sel ? vo2 : vo8;
    endfunction

    function automatic logic get_ready(input bit sel);
        return sel ? rdy2 : rdy8;
    endfunction

    function automatic logic [7:0] get_diff(input bit sel);
        return sel ? {6'd0, d2} : d8;
    endfunction

    function automatic logic get_borrow(input bit sel);
        return sel ? bo2 : bo8;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [7:0] a, input logic [7:0] b);
        if (sel) begin
            v2 = v; a2 = a[1:0]; b2 = b[1:0];
        end else begin
            v8 = v; a8 = a; b8 = b;
        end
    endtask

    task automatic set_ready(input bit sel, input logic r);
        if (sel) ri2 = r; else ri8 = r;
    endtask

    // One full operation. hold>0 keeps ready_i low for hold cycles in DONE
    // while presenting (na, nb) with valid_i high; those must not be taken.
    task automatic do_op(input bit sel, input logic [7:0] a_in, input logic [7:0] b_in,
                         input int hold, input logic [7:0] na, input logic [7:0] nb);
        int         width;
        logic [7:0] mask;
        logic [7:0] am, bm;
        exp_t       e;
        exp_t       got;
        int         edges;

        width = sel ? 2 : 8;
        mask  = sel ? 8'h03 : 8'hFF;
        am    = a_in & mask;
        bm    = b_in & mask;

        @(negedge clk);
        chk("ready_before_accept", 64'(get_ready(sel)), 64'd1);
        drive(sel, 1'b1, am, bm);
        set_ready(sel, hold == 0);
        e.diff   = (am - bm) & mask;
        e.borrow = (am < bm);
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        // Operands change right after acceptance; they must not matter.
        drive(sel, 1'b0, 8'($urandom), 8'($urandom));

        edges = 0;
        while (!get_valid(sel) && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("latency", 64'(edges), 64'(width));

        got = exp_q.pop_front();
        chk("diff", 64'(get_diff(sel)), 64'(got.diff));
        chk("borrow", 64'(get_borrow(sel)), 64'(got.borrow));
        $display("op w=%0d a=%02h b=%02h diff=%02h borrow=%0b exp_diff=%02h exp_borrow=%0b",
                 width, am, bm, get_diff(sel), get_borrow(sel), got.diff, got.borrow);

        if (hold > 0) begin
            drive(sel, 1'b1, na, nb);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                chk("hold_valid", 64'(get_valid(sel)), 64'd1);
                chk("hold_diff", 64'(get_diff(sel)), 64'(got.diff));
                chk("hold_borrow", 64'(get_borrow(sel)), 64'(got.borrow));
            end
            set_ready(sel, 1'b1);
        end

        // Edge leaving DONE: even with valid_i high, nothing is accepted.
        @(posedge clk);
        #1;
        chk("ready_after_done", 64'(get_ready(sel)), 64'd1);
        chk("valid_after_done", 64'(get_valid(sel)), 64'd0);
    endtask

    initial begin
        error_o = 1'b0;
        pass_o  = 1'b0;
        rst = 1'b1;
        v8 = 0; a8 = 0; b8 = 0; ri8 = 1;
        v2 = 0; a2 = 0; b2 = 0; ri2 = 1;

        // Reset for two cycles, then release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 64'(rdy8), 64'd1);
        chk("rst_valid", 64'(vo8), 64'd0);
        chk("rst_diff", 64'(d8), 64'd0);
        chk("rst_borrow", 64'(bo8), 64'd0);
        chk("rst_ready_w2", 64'(rdy2), 64'd1);
        chk("rst_valid_w2", 64'(vo2), 64'd0);

        do_op(1'b0, 8'h2A, 8'h0F, 0, 8'h00, 8'h00);
        do_op(1'b0, 8'h05, 8'h07, 0, 8'h00, 8'h00);
        do_op(1'b0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        do_op(1'b0, 8'h80, 8'h7F, 0, 8'h00, 8'h00);

        // Backpressure: five cycles in DONE with new operands on the input.
        do_op(1'b0, 8'h33, 8'h11, 5, 8'h44, 8'h45);
        do_op(1'b0, 8'h44, 8'h45, 0, 8'h00, 8'h00);

        // Mid-operation reset on the 4th BUSY edge.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hAB, 8'h12);
        exp_q.push_back('{diff: 8'h99, borrow: 1'b0});
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        $display("op w=8 a=ab b=12 aborted by reset");
        chk("abort_valid", 64'(vo8), 64'd0);
        chk("abort_ready", 64'(rdy8), 64'd1);
        chk("abort_diff", 64'(d8), 64'd0);
        chk("abort_borrow", 64'(bo8), 64'd0);
        repeat (12) begin
            @(posedge clk);
            #1;
            chk("abort_no_result", 64'(vo8), 64'd0);
        end

        do_op(1'b0, 8'hFF, 8'h01, 0, 8'h00, 8'h00);

        // Exhaustive at width 2.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                do_op(1'b1, 8'(a), 8'(b), 0, 8'h00, 8'h00);
            end
        end

        error_o = (bad != 0);
        pass_o  = (bad == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
